imem_boot_ctrl: RTL and testbench
=================================

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter DEPTH, 256, instruction words held in the internal store.
REQ-002 Parameter AW, 8, word-index width; SHALL equal clog2(DEPTH).
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_load_start  in  1  pulse; begin (re)load of program image.
REQ-006 i_load_valid  in  1  loader word valid.
REQ-007 i_load_data  in  32  loader word.
REQ-008 i_load_last  in  1  qualifies the final word of the image.
REQ-009 o_load_ready  out  1  block accepts a loader word this cycle.
REQ-010 o_load_done  out  1  one-cycle pulse when the image is committed.
REQ-011 o_load_csum  out  32  running checksum of loaded words (see Configuration).
REQ-012 i_fetch_req  in  1  fetch request from the IF stage.
REQ-013 i_fetch_addr  in  32  byte address of the requested instruction.
REQ-014 o_fetch_valid  out  1  o_fetch_instr is valid this cycle.
REQ-015 o_fetch_instr  out  32  fetched instruction, registered.
REQ-016 o_fetch_err  out  1  misaligned or out-of-range fetch, same cycle as o_fetch_valid.
REQ-017 o_core_stall  out  1  core SHALL hold PC; high in every state except RUN.

Function
REQ-018 FSM states BOOT, LOAD, RUN; a word is accepted when i_load_valid && o_load_ready.
REQ-019 BOOT: o_load_ready=0, o_core_stall=1; i_load_start -> LOAD next cycle.
REQ-020 LOAD: o_load_ready=1; each accepted word written at index wr_cnt, wr_cnt increments by 1.
REQ-021 LOAD exits to RUN when the accepted word has i_load_last=1 or wr_cnt==DEPTH-1 (no wrap); o_load_done pulses in the cycle after that acceptance.
REQ-022 Words not written during a load keep their previous contents.
REQ-023 RUN: fetch latency exactly 1 cycle; request in cycle N -> o_fetch_valid=1 in cycle N+1, fully pipelined, one request per cycle.
REQ-024 Word index = i_fetch_addr[AW+1:2]; if i_fetch_addr[1:0]!=0 or i_fetch_addr[31:AW+2]!=0, o_fetch_instr=32'h00000013 (NOP) and o_fetch_err=1.
REQ-025 i_fetch_req outside RUN is ignored; no o_fetch_valid results from it.
REQ-026 i_load_start in RUN -> LOAD next cycle, wr_cnt cleared to 0; a fetch requested in that same cycle SHALL be dropped (no o_fetch_valid).
REQ-027 i_load_start during LOAD restarts the image: wr_cnt=0, checksum cleared; a word presented in that cycle is not accepted.
REQ-028 o_fetch_valid, o_fetch_err, o_load_done are zero whenever no event defines them.

Reset
REQ-029 i_rst: state=BOOT, wr_cnt=0, o_load_done=0, o_fetch_valid=0, o_fetch_err=0, o_fetch_instr=0, o_load_csum=0; store contents are not reset.
REQ-030 i_rst mid-LOAD or mid-fetch aborts the operation; no o_load_done or o_fetch_valid follows.

Configuration
REQ-031 Macro IMEM_LOAD_CHECKSUM_EN defined: o_load_csum = 32-bit wrapping sum of accepted words since last load start, cleared on i_load_start.
REQ-032 Macro undefined: o_load_csum tied to 0, no adder logic present.

Structure
REQ-033 Package imem_ctrl_pkg holds the state enum, the NOP constant 32'h00000013, and the default DEPTH.
REQ-034 Sub-module imem_ram: DEPTH x 32 array, synchronous write port, asynchronous read port; instantiated once.

Verification
REQ-035 Reset, i_load_start, 4 words 0x11,0x22,0x33,0x44 (last on 4th) -> o_load_done one cycle after 4th word, state RUN, o_core_stall=0.
REQ-036 After REQ-035 image, fetches at 0x0,0x4,0x8,0xC back-to-back -> o_fetch_instr 0x11,0x22,0x33,0x44 on consecutive cycles, o_fetch_err=0.
REQ-037 Fetch 0x6 and 0x400 with DEPTH=256 -> o_fetch_instr=0x00000013, o_fetch_err=1 for each.
REQ-038 Stream 256 words without i_load_last -> done after word 256; fetch 0x3FC returns word 256.
REQ-039 i_rst asserted after 2 of 4 load words -> state BOOT, no o_load_done, o_load_csum=0.
REQ-040 With IMEM_LOAD_CHECKSUM_EN, words 0xFFFFFFFF and 0x2 -> o_load_csum=0x00000001; without the macro -> 0.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT,
        LOAD,
        RUN
    } state_t;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH = 256;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction store: synchronous write, asynchronous read, no reset.
module imem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot-time program loader and 1-cycle fetch port for the core's instruction memory.
// Optional load checksum enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_boot_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_start,
    input  logic        i_load_valid,
    input  logic [31:0] i_load_data,
    input  logic        i_load_last,
    output logic        o_load_ready,
    output logic        o_load_done,
    output logic [31:0] o_load_csum,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_addr,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_instr,
    output logic        o_fetch_err,
    output logic        o_core_stall
);

    state_t        state;
    logic [AW-1:0] wr_cnt;
    logic          accept;
    logic          bad_addr;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_data;

    // A restart cycle never accepts a word, so ready drops while i_load_start is high.
    assign o_load_ready = (state == LOAD) && !i_load_start;
    assign o_core_stall = (state != RUN);
    assign accept       = i_load_valid && o_load_ready;
    assign rd_idx       = i_fetch_addr[AW+1:2];
    assign bad_addr     = (i_fetch_addr[1:0] != 2'b00) || (i_fetch_addr[31:AW+2] != '0);

    imem_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (i_clk),
        .we   (accept),
        .waddr(wr_cnt),
        .wdata(i_load_data),
        .raddr(rd_idx),
        .rdata(rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= BOOT;
            wr_cnt        <= '0;
            o_load_done   <= 1'b0;
            o_fetch_valid <= 1'b0;
            o_fetch_err   <= 1'b0;
            o_fetch_instr <= '0;
        end else begin
            o_load_done   <= 1'b0;
            o_fetch_valid <= 1'b0;
            o_fetch_err   <= 1'b0;
            case (state)
                BOOT: begin
                    if (i_load_start) begin
                        state  <= LOAD;
                        wr_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (i_load_start) begin
                        wr_cnt <= '0;
                    end else if (accept) begin
                        wr_cnt <= wr_cnt + AW'(1);
                        if (i_load_last || (wr_cnt == AW'(DEPTH - 1))) begin
                            state       <= RUN;
                            o_load_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (i_load_start) begin
                        state  <= LOAD;
                        wr_cnt <= '0;
                    end else if (i_fetch_req) begin
                        o_fetch_valid <= 1'b1;
                        o_fetch_err   <= bad_addr;
                        o_fetch_instr <= bad_addr ? NOP_INSTR : rd_data;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load_start) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + i_load_data;
        end
    end

    assign o_load_csum = csum;
`else
    assign o_load_csum = '0;
`endif

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl against an array-based reference of the image.
module tb_imem_boot_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_load_start = 1'b0;
    logic        i_load_valid = 1'b0;
    logic [31:0] i_load_data = '0;
    logic        i_load_last = 1'b0;
    logic        o_load_ready;
    logic        o_load_done;
    logic [31:0] o_load_csum;
    logic        i_fetch_req = 1'b0;
    logic [31:0] i_fetch_addr = '0;
    logic        o_fetch_valid;
    logic [31:0] o_fetch_instr;
    logic        o_fetch_err;
    logic        o_core_stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [256];
    logic [31:0] csum_m;

    imem_boot_ctrl #(.DEPTH(256), .AW(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load_start (i_load_start),
        .i_load_valid (i_load_valid),
        .i_load_data  (i_load_data),
        .i_load_last  (i_load_last),
        .o_load_ready (o_load_ready),
        .o_load_done  (o_load_done),
        .o_load_csum  (o_load_csum),
        .i_fetch_req  (i_fetch_req),
        .i_fetch_addr (i_fetch_addr),
        .o_fetch_valid(o_fetch_valid),
        .o_fetch_instr(o_fetch_instr),
        .o_fetch_err  (o_fetch_err),
        .o_core_stall (o_core_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] exp_csum(input logic [31:0] s);
`ifdef IMEM_LOAD_CHECKSUM_EN
        return s;
`else
        return 32'h0;
`endif
    endfunction

    // Expected fetch result from the address rules alone.
    function automatic logic exp_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        return exp_bad(a) ? NOP : mem_m[a / 4];
    endfunction

    task automatic test_reset();
        i_rst = 1'b1;
        i_fetch_req = 1'b1;
        tick();
        i_rst = 1'b0;
        csum_m = '0;
        checks++;
        if ({o_core_stall, o_load_ready, o_load_done, o_fetch_valid, o_fetch_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 10000",
                     {o_core_stall, o_load_ready, o_load_done, o_fetch_valid, o_fetch_err});
        end
        checks++;
        if (o_fetch_instr !== 32'h0 || o_load_csum !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs got instr %h csum %h exp 0 0", o_fetch_instr, o_load_csum);
        end
        tick();
        checks++;
        if (o_fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_fetch_ignored got %b exp 0", o_fetch_valid);
        end
        i_fetch_req = 1'b0;
    endtask

    task automatic test_load_basic();
        logic [31:0] w [4];
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        csum_m = '0;
        #1;
        checks++;
        if (o_core_stall !== 1'b1 || o_load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_enter got stall %b ready %b exp 1 1", o_core_stall, o_load_ready);
        end
        for (int k = 0; k < 4; k++) begin
            i_load_valid = 1'b1;
            i_load_data = w[k];
            i_load_last = (k == 3);
            tick();
            mem_m[k] = w[k];
            csum_m = csum_m + w[k];
            checks++;
            if (o_load_done !== (k == 3)) begin
                errors++;
                $display("FAIL load_done_timing word %0d got %b exp %b", k, o_load_done, k == 3);
            end
        end
        i_load_valid = 1'b0;
        i_load_last = 1'b0;
        #1;
        checks++;
        if (o_core_stall !== 1'b0 || o_load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_to_run got stall %b ready %b exp 0 0", o_core_stall, o_load_ready);
        end
        checks++;
        if (o_load_csum !== exp_csum(csum_m)) begin
            errors++;
            $display("FAIL load_csum got %h exp %h", o_load_csum, exp_csum(csum_m));
        end
        tick();
        checks++;
        if (o_load_done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle got %b exp 0", o_load_done);
        end
    endtask

    task automatic test_fetch_b2b();
        for (int k = 0; k < 4; k++) begin
            i_fetch_req = 1'b1;
            i_fetch_addr = 32'(k * 4);
            tick();
            checks++;
            if (o_fetch_valid !== 1'b1 || o_fetch_err !== 1'b0 || o_fetch_instr !== 32'(8'h11 * (k + 1))) begin
                errors++;
                $display("FAIL fetch_b2b k=%0d got v%b e%b %h exp v1 e0 %h",
                         k, o_fetch_valid, o_fetch_err, o_fetch_instr, 32'(8'h11 * (k + 1)));
            end
        end
        i_fetch_req = 1'b0;
        tick();
        checks++;
        if (o_fetch_valid !== 1'b0 || o_fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle got v%b e%b exp v0 e0", o_fetch_valid, o_fetch_err);
        end
    endtask

    task automatic test_fetch_err();
        logic [31:0] a [6];
        a[0] = 32'h6;
        a[1] = 32'h400;
        a[2] = 32'h8000_0000;
        a[3] = ($urandom_range(0, 255) * 4) | $urandom_range(1, 3);
        a[4] = 32'h3FD;
        a[5] = 32'h0000_0400 + ($urandom_range(0, 255) * 4);
        for (int k = 0; k < 6; k++) begin
            i_fetch_req = 1'b1;
            i_fetch_addr = a[k];
            tick();
            checks++;
            if (o_fetch_valid !== 1'b1 || o_fetch_err !== 1'b1 || o_fetch_instr !== NOP) begin
                errors++;
                $display("FAIL fetch_err addr %h got v%b e%b %h exp v1 e1 %h",
                         a[k], o_fetch_valid, o_fetch_err, o_fetch_instr, NOP);
            end
        end
        i_fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_csum();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        i_load_valid = 1'b1;
        i_load_data = 32'hFFFF_FFFF;
        tick();
        i_load_data = 32'h2;
        i_load_last = 1'b1;
        tick();
        mem_m[0] = 32'hFFFF_FFFF;
        mem_m[1] = 32'h2;
        i_load_valid = 1'b0;
        i_load_last = 1'b0;
        checks++;
`ifdef IMEM_LOAD_CHECKSUM_EN
        if (o_load_csum !== 32'h1) begin
            errors++;
            $display("FAIL csum_wrap got %h exp %h", o_load_csum, 32'h1);
        end
`else
        if (o_load_csum !== 32'h0) begin
            errors++;
            $display("FAIL csum_wrap got %h exp %h", o_load_csum, 32'h0);
        end
`endif
    endtask

    task automatic test_restart();
        logic [31:0] a, b, c, d;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        i_load_valid = 1'b1;
        i_load_data = a;
        tick();
        i_load_data = b;
        tick();
        mem_m[0] = a;
        mem_m[1] = b;
        i_load_start = 1'b1;
        i_load_data = c;
        #1;
        checks++;
        if (o_load_ready !== 1'b0) begin
            errors++;
            $display("FAIL restart_ready got %b exp 0", o_load_ready);
        end
        tick();
        i_load_start = 1'b0;
        i_load_data = d;
        i_load_last = 1'b1;
        tick();
        mem_m[0] = d;
        i_load_valid = 1'b0;
        i_load_last = 1'b0;
        checks++;
        if (o_load_done !== 1'b1 || o_load_csum !== exp_csum(d)) begin
            errors++;
            $display("FAIL restart_done got done %b csum %h exp 1 %h", o_load_done, o_load_csum, exp_csum(d));
        end
        for (int k = 0; k < 3; k++) begin
            i_fetch_req = 1'b1;
            i_fetch_addr = 32'(k * 4);
            tick();
            checks++;
            if (o_fetch_valid !== 1'b1 || o_fetch_instr !== mem_m[k]) begin
                errors++;
                $display("FAIL restart_image idx %0d got v%b %h exp v1 %h", k, o_fetch_valid, o_fetch_instr, mem_m[k]);
            end
        end
        i_fetch_req = 1'b0;
    endtask

    task automatic test_start_drops_fetch();
        logic [31:0] e;
        e = $urandom;
        i_fetch_req = 1'b1;
        i_fetch_addr = 32'h0;
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        checks++;
        if (o_fetch_valid !== 1'b0 || o_core_stall !== 1'b1) begin
            errors++;
            $display("FAIL start_drops_fetch got v%b stall %b exp v0 stall 1", o_fetch_valid, o_core_stall);
        end
        tick();
        checks++;
        if (o_fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_fetch_ignored got %b exp 0", o_fetch_valid);
        end
        i_fetch_req = 1'b0;
        i_load_valid = 1'b1;
        i_load_data = e;
        i_load_last = 1'b1;
        tick();
        mem_m[0] = e;
        i_load_valid = 1'b0;
        i_load_last = 1'b0;
        checks++;
        if (o_load_done !== 1'b1 || o_load_csum !== exp_csum(e)) begin
            errors++;
            $display("FAIL reload_done got done %b csum %h exp 1 %h", o_load_done, o_load_csum, exp_csum(e));
        end
    endtask

    task automatic test_full_load();
        int n;
        logic v;
        n = 0;
        csum_m = '0;
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        while (n < 256) begin
            v = ($urandom_range(0, 3) != 0);
            i_load_valid = v;
            i_load_data = $urandom;
            i_load_last = 1'b0;
            #1;
            checks++;
            if (o_load_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_ready word %0d got %b exp 1", n, o_load_ready);
            end
            tick();
            if (v) begin
                mem_m[n] = i_load_data;
                csum_m = csum_m + i_load_data;
                n++;
            end
            checks++;
            if (o_load_done !== (v && n == 256)) begin
                errors++;
                $display("FAIL full_done word %0d got %b exp %b", n, o_load_done, v && n == 256);
            end
        end
        i_load_valid = 1'b0;
        #1;
        checks++;
        if (o_core_stall !== 1'b0 || o_load_ready !== 1'b0 || o_load_csum !== exp_csum(csum_m)) begin
            errors++;
            $display("FAIL full_run got stall %b ready %b csum %h exp 0 0 %h",
                     o_core_stall, o_load_ready, o_load_csum, exp_csum(csum_m));
        end
        i_fetch_req = 1'b1;
        i_fetch_addr = 32'h3FC;
        tick();
        i_fetch_req = 1'b0;
        checks++;
        if (o_fetch_valid !== 1'b1 || o_fetch_err !== 1'b0 || o_fetch_instr !== mem_m[255]) begin
            errors++;
            $display("FAIL full_last_word got v%b e%b %h exp v1 e0 %h",
                     o_fetch_valid, o_fetch_err, o_fetch_instr, mem_m[255]);
        end
    endtask

    task automatic test_random_fetch(input int cycles);
        logic        req;
        logic [31:0] a;
        for (int c = 0; c < cycles; c++) begin
            req = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255) * 4);
            i_fetch_req = req;
            i_fetch_addr = a;
            tick();
            checks++;
            if (o_fetch_valid !== req || o_fetch_err !== (req && exp_bad(a)) ||
                (req && o_fetch_instr !== exp_instr(a))) begin
                errors++;
                $display("FAIL rand_fetch addr %h req %b got v%b e%b %h exp v%b e%b %h",
                         a, req, o_fetch_valid, o_fetch_err, o_fetch_instr,
                         req, req && exp_bad(a), exp_instr(a));
            end
        end
        i_fetch_req = 1'b0;
    endtask

    task automatic test_partial_reload();
        int n;
        n = $urandom_range(2, 6);
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_load_valid = 1'b1;
            i_load_data = $urandom;
            i_load_last = (k == n - 1);
            tick();
            mem_m[k] = i_load_data;
        end
        i_load_valid = 1'b0;
        i_load_last = 1'b0;
        checks++;
        if (o_load_done !== 1'b1) begin
            errors++;
            $display("FAIL partial_done got %b exp 1", o_load_done);
        end
        for (int k = 0; k < n + 3; k++) begin
            i_fetch_req = 1'b1;
            i_fetch_addr = 32'(k * 4);
            tick();
            checks++;
            if (o_fetch_valid !== 1'b1 || o_fetch_instr !== mem_m[k]) begin
                errors++;
                $display("FAIL partial_keep idx %0d got v%b %h exp v1 %h", k, o_fetch_valid, o_fetch_instr, mem_m[k]);
            end
        end
        i_fetch_req = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_load_valid = 1'b1;
            i_load_data = 32'(8'h11 * (k + 1));
            tick();
            mem_m[k] = i_load_data;
        end
        i_load_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_core_stall !== 1'b1 || o_load_ready !== 1'b0 || o_load_done !== 1'b0 || o_load_csum !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_load got stall %b ready %b done %b csum %h exp 1 0 0 0",
                     o_core_stall, o_load_ready, o_load_done, o_load_csum);
        end
        tick();
        checks++;
        if (o_load_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done got %b exp 0", o_load_done);
        end
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        i_load_valid = 1'b1;
        i_load_data = $urandom;
        i_load_last = 1'b1;
        tick();
        mem_m[0] = i_load_data;
        i_load_valid = 1'b0;
        i_load_last = 1'b0;
        i_fetch_req = 1'b1;
        i_fetch_addr = 32'h0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_fetch_req = 1'b0;
        checks++;
        if (o_fetch_valid !== 1'b0 || o_core_stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_fetch got v%b stall %b exp v0 stall 1", o_fetch_valid, o_core_stall);
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_fetch_b2b();
        test_fetch_err();
        test_csum();
        test_restart();
        test_start_drops_fetch();
        test_full_load();
        test_random_fetch(300);
        test_partial_reload();
        test_random_fetch(100);
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
